complex_mult_pipe: RTL and testbench

Parametrised, fully pipelined signed complex multiplier for the OFDM receive datapath (channel equalisation, CFO de-rotation, correlation). It multiplies `a` by `b` or by `conj(b)`, selected per sample, and rescales the exact result to a configurable output width with rounding and saturation. It stalls on `enable`, and its output is registered with a fixed latency of 4 enabled cycles.

---
 rtl/mult_pkg.sv | 14 +
 rtl/complex_mult_pipe_if.sv | 30 +++
 rtl/cplx_round_sat.sv | 51 +++++
 rtl/complex_mult_pipe.sv | 111 +++++++++++
 tb/tb_complex_mult_pipe.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared constants and width helper for the complex multiplier pipeline.
// Imported by the interface user (top) and the testbench.
package mult_pkg;

  localparam int   CMULT_LATENCY = 4;
  localparam logic MODE_NORMAL   = 1'b0;
  localparam logic MODE_CONJ     = 1'b1;

  // Exact width of a sum of two IN_WIDTH x IN_WIDTH signed products.
  function automatic int FULL(input int in_width);
    return 2 * in_width + 1;
  endfunction

endpackage

// File: rtl/complex_mult_pipe_if.sv
// Operand/result bundle for complex_mult_pipe; master drives samples, slave is the multiplier.
// Strobes qualify data; the pipeline itself is stalled by the separate enable input.
interface complex_mult_pipe_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
);

  logic signed [IN_WIDTH-1:0]  a_i;
  logic signed [IN_WIDTH-1:0]  a_q;
  logic signed [IN_WIDTH-1:0]  b_i;
  logic signed [IN_WIDTH-1:0]  b_q;
  logic                        conj_b;
  logic                        input_strobe;

  logic signed [OUT_WIDTH-1:0] p_i;
  logic signed [OUT_WIDTH-1:0] p_q;
  logic                        sat_flag;
  logic                        output_strobe;

  modport master (
    output a_i, a_q, b_i, b_q, conj_b, input_strobe,
    input  p_i, p_q, sat_flag, output_strobe
  );

  modport slave (
    input  a_i, a_q, b_i, b_q, conj_b, input_strobe,
    output p_i, p_q, sat_flag, output_strobe
  );

endinterface

// File: rtl/cplx_round_sat.sv
// Round-half-up, arithmetic shift and saturate one FULL-bit component into a registered OUT_WIDTH result.
// One cycle; loads only on enable && load, otherwise holds the last result.
module cplx_round_sat #(
  parameter int FULL      = 33,
  parameter int OUT_WIDTH = 32,
  parameter int OUT_SHIFT = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        load,
  input  logic signed [FULL-1:0]      din,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        clip
);

  // One guard bit: the largest positive input plus the rounding constant can reach 2^(FULL-1).
  localparam int RW = FULL + 1;
  localparam logic signed [RW-1:0] RND  = (RW'(1) << OUT_SHIFT) >> 1;
  localparam logic signed [RW-1:0] MAXV = (RW'(1) << (OUT_WIDTH - 1)) - RW'(1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  logic signed [RW-1:0] rounded;
  logic signed [RW-1:0] shifted;
  logic                 hi;
  logic                 lo;

  always_comb begin
    rounded = {din[FULL-1], din} + RND;
    shifted = rounded >>> OUT_SHIFT;
    hi      = shifted > MAXV;
    lo      = shifted < MINV;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dout <= '0;
      clip <= 1'b0;
    end else if (enable && load) begin
      clip <= hi | lo;
      if (hi) begin
        dout <= MAXV[OUT_WIDTH-1:0];
      end else if (lo) begin
        dout <= MINV[OUT_WIDTH-1:0];
      end else begin
        dout <= shifted[OUT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/complex_mult_pipe.sv
// Fully pipelined signed complex multiply a*b or a*conj(b), rounded/saturated to OUT_WIDTH; 4 enabled cycles.
// enable low freezes every register including output_strobe; no ready path back to the source.
module complex_mult_pipe
  import mult_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32,
  parameter int OUT_SHIFT = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  complex_mult_pipe_if.slave  bus
);

  localparam int FW = FULL(IN_WIDTH);
  localparam int PW = 2 * IN_WIDTH;

  logic signed [IN_WIDTH-1:0] s1_ai;
  logic signed [IN_WIDTH-1:0] s1_aq;
  logic signed [IN_WIDTH-1:0] s1_bi;
  logic signed [IN_WIDTH-1:0] s1_bq;
  logic                       s1_conj;
  logic                       s1_vld;

  logic signed [PW-1:0]       s2_ii;
  logic signed [PW-1:0]       s2_qq;
  logic signed [PW-1:0]       s2_iq;
  logic signed [PW-1:0]       s2_qi;
  logic                       s2_conj;
  logic                       s2_vld;

  logic signed [FW-1:0]       s3_re;
  logic signed [FW-1:0]       s3_im;
  logic                       s3_vld;

  logic                       s4_vld;
  logic                       clip_i;
  logic                       clip_q;

  // Valid bits are the only pipeline state that sees reset, so in-flight samples are dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s3_vld <= 1'b0;
      s4_vld <= 1'b0;
    end else if (enable) begin
      s1_vld <= bus.input_strobe;
      s2_vld <= s1_vld;
      s3_vld <= s2_vld;
      s4_vld <= s3_vld;
    end
  end

  always_ff @(posedge clock) begin
    if (enable) begin
      s1_ai   <= bus.a_i;
      s1_aq   <= bus.a_q;
      s1_bi   <= bus.b_i;
      s1_bq   <= bus.b_q;
      s1_conj <= bus.conj_b;

      s2_ii   <= PW'(s1_ai) * PW'(s1_bi);
      s2_qq   <= PW'(s1_aq) * PW'(s1_bq);
      s2_iq   <= PW'(s1_ai) * PW'(s1_bq);
      s2_qi   <= PW'(s1_aq) * PW'(s1_bi);
      s2_conj <= s1_conj;

      if (s2_conj == MODE_CONJ) begin
        s3_re <= FW'(s2_ii) + FW'(s2_qq);
        s3_im <= FW'(s2_qi) - FW'(s2_iq);
      end else begin
        s3_re <= FW'(s2_ii) - FW'(s2_qq);
        s3_im <= FW'(s2_iq) + FW'(s2_qi);
      end
    end
  end

  cplx_round_sat #(
    .FULL      (FW),
    .OUT_WIDTH (OUT_WIDTH),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_rs_i (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .load   (s3_vld),
    .din    (s3_re),
    .dout   (bus.p_i),
    .clip   (clip_i)
  );

  cplx_round_sat #(
    .FULL      (FW),
    .OUT_WIDTH (OUT_WIDTH),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_rs_q (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .load   (s3_vld),
    .din    (s3_im),
    .dout   (bus.p_q),
    .clip   (clip_q)
  );

  assign bus.output_strobe = s4_vld;
  assign bus.sat_flag      = clip_i | clip_q;

endmodule

// File: tb/tb_complex_mult_pipe.sv
// Bench for complex_mult_pipe: default and 16-bit/shift-15 instances share one stimulus stream.
// Outputs are checked every cycle against a queue-based arithmetic reference, plus literal expectations.
module tb_complex_mult_pipe;
  import mult_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;

  always #5 clock = ~clock;

  logic signed [15:0] ai = '0;
  logic signed [15:0] aq = '0;
  logic signed [15:0] bi = '0;
  logic signed [15:0] bq = '0;
  logic               cj_in = 1'b0;
  logic               strb = 1'b0;

  complex_mult_pipe_if #(.IN_WIDTH(16), .OUT_WIDTH(32)) bus_a ();
  complex_mult_pipe_if #(.IN_WIDTH(16), .OUT_WIDTH(16)) bus_b ();

  assign bus_a.a_i = ai;
  assign bus_a.a_q = aq;
  assign bus_a.b_i = bi;
  assign bus_a.b_q = bq;
  assign bus_a.conj_b = cj_in;
  assign bus_a.input_strobe = strb;
  assign bus_b.a_i = ai;
  assign bus_b.a_q = aq;
  assign bus_b.b_i = bi;
  assign bus_b.b_q = bq;
  assign bus_b.conj_b = cj_in;
  assign bus_b.input_strobe = strb;

  complex_mult_pipe #(.IN_WIDTH(16), .OUT_WIDTH(32), .OUT_SHIFT(0)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .bus(bus_a)
  );

  complex_mult_pipe #(.IN_WIDTH(16), .OUT_WIDTH(16), .OUT_SHIFT(15)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .bus(bus_b)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference arithmetic: exact product, round-half-up, arithmetic shift, clip.
  function automatic void scale_sat(input longint v, input int ow, input int sh,
                                    output longint r, output bit c);
    longint mx;
    longint mn;
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v  = v >>> sh;
    mx = (longint'(1) << (ow - 1)) - 1;
    mn = -mx - 1;
    c  = 1'b1;
    if (v > mx)      r = mx;
    else if (v < mn) r = mn;
    else begin
      r = v;
      c = 1'b0;
    end
  endfunction

  function automatic void ref_mul(input longint xai, input longint xaq, input longint xbi,
                                  input longint xbq, input bit cj, input int ow, input int sh,
                                  output longint ri, output longint rq, output bit sat);
    longint re;
    longint im;
    bit ci;
    bit cq;
    if (cj) begin
      re = xai * xbi + xaq * xbq;
      im = xaq * xbi - xai * xbq;
    end else begin
      re = xai * xbi - xaq * xbq;
      im = xai * xbq + xaq * xbi;
    end
    scale_sat(re, ow, sh, ri, ci);
    scale_sat(im, ow, sh, rq, cq);
    sat = ci | cq;
  endfunction

  typedef struct {
    int     k;
    longint ia;
    longint qa;
    bit     sa;
    longint ib;
    longint qb;
    bit     sb;
  } ent_t;

  ent_t q[$];
  ent_t last;
  ent_t new_e;
  int   ecount = 0;
  bit   exp_strobe = 1'b0;
  bit   armed = 1'b0;

  // Sample accepted on enabled edge k is visible after enabled edge k+LAT-1 until the next enabled edge.
  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      last = '{default: 0};
      exp_strobe = 1'b0;
      armed = 1'b1;
    end else if (enable) begin
      ecount++;
      if (strb) begin
        new_e.k = ecount;
        ref_mul(ai, aq, bi, bq, cj_in, 32, 0, new_e.ia, new_e.qa, new_e.sa);
        ref_mul(ai, aq, bi, bq, cj_in, 16, 15, new_e.ib, new_e.qb, new_e.sb);
        q.push_back(new_e);
      end
      while (q.size() > 0 && q[0].k + CMULT_LATENCY - 1 < ecount) void'(q.pop_front());
      if (q.size() > 0 && q[0].k + CMULT_LATENCY - 1 == ecount) begin
        exp_strobe = 1'b1;
        last = q[0];
      end else begin
        exp_strobe = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      chk("strobe_a", bus_a.output_strobe, exp_strobe);
      chk("p_i_a", bus_a.p_i, last.ia);
      chk("p_q_a", bus_a.p_q, last.qa);
      chk("sat_a", bus_a.sat_flag, last.sa);
      chk("strobe_b", bus_b.output_strobe, exp_strobe);
      chk("p_i_b", bus_b.p_i, last.ib);
      chk("p_q_b", bus_b.p_q, last.qb);
      chk("sat_b", bus_b.sat_flag, last.sb);
    end
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic set_in(input int xai, input int xaq, input int xbi, input int xbq,
                        input bit cj, input bit st);
    ai = 16'(xai);
    aq = 16'(xaq);
    bi = 16'(xbi);
    bq = 16'(xbq);
    cj_in = cj;
    strb = st;
  endtask

  // Present one sample, then idle until the cycle its result must be visible.
  task automatic send1(input int xai, input int xaq, input int xbi, input int xbq, input bit cj);
    set_in(xai, xaq, xbi, xbq, cj, 1'b1);
    step();
    strb = 1'b0;
    repeat (3) step();
  endtask

  function automatic int rv();
    case ($urandom_range(0, 5))
      0: return -32768;
      1: return 32767;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  initial begin
    repeat (3) step();
    reset = 1'b0;
    chk("rst_p_i", bus_a.p_i, 0);
    chk("rst_p_q", bus_a.p_q, 0);
    chk("rst_sat", bus_a.sat_flag, 0);
    chk("rst_strobe", bus_a.output_strobe, 0);

    set_in(3, 4, 5, -2, 1'b0, 1'b1);
    step();
    strb = 1'b0;
    repeat (2) step();
    chk("lat_early_strobe", bus_a.output_strobe, 0);
    step();
    chk("lat_strobe", bus_a.output_strobe, 1);
    chk("norm_p_i", bus_a.p_i, 23);
    chk("norm_p_q", bus_a.p_q, 14);
    chk("norm_sat", bus_a.sat_flag, 0);

    send1(3, 4, 5, -2, 1'b1);
    chk("conj_p_i", bus_a.p_i, 7);
    chk("conj_p_q", bus_a.p_q, 26);

    send1(-32768, -32768, -32768, -32768, 1'b1);
    chk("neg_conj_p_i", bus_a.p_i, 2147483647);
    chk("neg_conj_p_q", bus_a.p_q, 0);
    chk("neg_conj_sat", bus_a.sat_flag, 1);
    send1(-32768, -32768, -32768, -32768, 1'b0);

    send1(1, 0, 16384, 0, 1'b0);
    chk("sh_half_up", bus_b.p_i, 1);
    send1(1, 0, 16383, 0, 1'b0);
    chk("sh_below_half", bus_b.p_i, 0);
    send1(-1, 0, 16384, 0, 1'b0);
    chk("sh_neg_half", bus_b.p_i, 0);
    send1(16384, 0, 16384, 0, 1'b0);
    chk("sh_quarter", bus_b.p_i, 8192);

    for (int i = 0; i < 8; i++) begin
      set_in(rv(), rv(), rv(), rv(), i[0], 1'b1);
      step();
    end
    strb = 1'b0;
    repeat (6) step();

    for (int i = 0; i < 12; i++) begin
      set_in(rv(), rv(), rv(), rv(), 1'($urandom_range(0, 1)), 1'b1);
      step();
      if (i == 5) begin
        enable = 1'b0;
        repeat (3) begin
          set_in(rv(), rv(), rv(), rv(), 1'($urandom_range(0, 1)), 1'b1);
          step();
        end
        enable = 1'b1;
      end
    end
    strb = 1'b0;
    repeat (6) step();

    for (int i = 0; i < 3; i++) begin
      set_in(rv(), rv(), rv(), rv(), 1'($urandom_range(0, 1)), 1'b1);
      step();
    end
    strb = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_p_i", bus_a.p_i, 0);
    chk("midrst_p_q", bus_a.p_q, 0);
    chk("midrst_sat", bus_a.sat_flag, 0);
    chk("midrst_strobe", bus_a.output_strobe, 0);
    send1(3, 4, 5, -2, 1'b0);
    chk("postrst_strobe", bus_a.output_strobe, 1);
    chk("postrst_p_i", bus_a.p_i, 23);

    repeat (400) begin
      enable = ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 99) == 0);
      set_in(rv(), rv(), rv(), rv(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step();
    end
    reset = 1'b0;
    enable = 1'b1;
    strb = 1'b0;
    repeat (8) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
